regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Integer register file (x0..x31) for the RV32 pipeline. It is the receiving end of the writeback interface (op_write / write_addr / write_data) and serves the two decode-stage read ports.
- Includes write-to-read bypass and a per-register pending-write scoreboard. Decode uses the scoreboard to stall on RAW hazards until the producing instruction reaches writeback.

Parameters:
- XLEN, 32, register data width
- NREG, 32, number of architectural registers (address width = 5)
- CNT_W, 2, width of per-register in-flight write counter (max CNT_MAX = 2^CNT_W-1 = 3 outstanding writes)

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  synchronous, active-high reset
- op_write  input  1  writeback write enable
- write_addr  input  5  writeback destination register
- write_data  input  XLEN  writeback data
- rs1_addr  input  5  decode read port 1 address
- rs2_addr  input  5  decode read port 2 address
- rs1_used  input  1  instruction in decode reads rs1
- rs2_used  input  1  instruction in decode reads rs2
- rs1_data  output  XLEN  read data port 1 (combinational)
- rs2_data  output  XLEN  read data port 2 (combinational)
- issue_valid  input  1  decode wants to issue an instruction this cycle
- issue_we  input  1  issuing instruction writes a register
- issue_rd  input  5  issuing instruction's destination
- flush  input  1  pipeline flush; discard all pending-write tracking
- stall  output  1  decode must hold; issue not accepted
- pending_any  output  1  at least one register counter nonzero

Behaviour:
- Reset (rst=1 at clk edge): all registers = 0, all counters = 0. Outputs during reset cycle follow combinational rules on cleared state: stall=0, pending_any=0, rsN_data=0 unless bypassed.
- Write: at clk edge, if op_write && write_addr!=0, regs[write_addr] <= write_data. Writes to x0 are dropped; x0 always reads 0.
- Read: rsN_data = 0 if rsN_addr==0.
  - Else if op_write && write_addr==rsN_addr, rsN_data = write_data (same-cycle bypass).
  - Else rsN_data = regs[rsN_addr].
- Effective count for a register r: eff(r) = cnt[r] − (op_write && write_addr==r && r!=0 && cnt[r]>0 ? 1 : 0).
- stall = 1 if any of the following holds:
  - rs1_used && rs1_addr!=0 && eff(rs1_addr)>0
  - rs2_used && rs2_addr!=0 && eff(rs2_addr)>0
  - issue_valid && issue_we && issue_rd!=0 && eff(issue_rd)==CNT_MAX
- stall is forced 0 when flush=1.
- issue_accept = issue_valid && !stall && !flush. The counter update applies only if issue_we && issue_rd!=0.
- Counter update per register at clk edge:
  - inc = issue_accept for this register; dec = writeback to this register.
  - inc&&dec → unchanged.
  - inc only → +1.
  - dec only → −1, saturating at 0; a writeback to a counter already at 0 is legal, and the data is still written.
- flush=1: all counters <= 0 next edge. The register write from the same-cycle writeback still occurs. Issue in the flush cycle is ignored.
- rst takes priority over flush, issue and write.
- pending_any = OR of (cnt[r]!=0) over registered state.
- Latency:
  - Write visible to reads via bypass in the same cycle; from array the next cycle.
  - Counter change visible in stall the next cycle, except the writeback decrement, which is visible the same cycle via eff().

Test Plan:
- Reset then read: rst 1 cycle; rs1_addr=5, rs2_addr=0 → rs1_data=0, rs2_data=0, stall=0, pending_any=0.
- Write/bypass: op_write=1, write_addr=7, write_data=0xDEADBEEF, rs1_addr=7 → rs1_data=0xDEADBEEF the same cycle. Next cycle with op_write=0 → rs1_data=0xDEADBEEF. A write to x0 of 0x1234 → x0 still reads 0.
- RAW stall: issue_valid=1, issue_we=1, issue_rd=3 (accepted) → cnt[3]=1, pending_any=1. Next cycle rs1_used=1, rs1_addr=3 → stall=1. In the writeback cycle with op_write=1, write_addr=3, write_data=0x55 → stall=0 and rs1_data=0x55.
- Saturation: three accepted issues to rd=9 with no writeback → cnt=3. A fourth issue to rd=9 → stall=1 and the counter stays 3. Three writebacks to 9 → cnt=0, pending_any=0.
- Simultaneous: cnt[4]=1, accepted issue to rd=4 and writeback to 4 in the same cycle → cnt[4] stays 1. A reader of x4 sees stall=0 in that cycle (eff=0) and stall=1 the next cycle.
- Flush: cnt[2]=2, cnt[6]=1, assert flush with issue_valid=1, issue_rd=8 → next cycle all counters 0, pending_any=0, x8 not pending. A later writeback to 2 leaves cnt at 0 and updates the data.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//
// Integer register file (x0..x31) with a per-register pending-write
// scoreboard. Writeback writes the array and bypasses to both decode read
// ports in the same cycle. Decode issues are counted per destination
// register; reads of a register with outstanding writes stall decode.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (clears array and counters)
//   op_write     writeback write enable
//   write_addr   writeback destination register
//   write_data   writeback data
//   rs1_addr     decode read port 1 address
//   rs2_addr     decode read port 2 address
//   rs1_used     decode instruction reads rs1
//   rs2_used     decode instruction reads rs2
//   rs1_data     read data port 1 (combinational, with writeback bypass)
//   rs2_data     read data port 2 (combinational, with writeback bypass)
//   issue_valid  decode wants to issue this cycle
//   issue_we     issuing instruction writes a register
//   issue_rd     issuing instruction's destination
//   flush        discard all pending-write tracking
//   stall        decode must hold; issue not accepted
//   pending_any  at least one register has outstanding writes
// ----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_write,
    input  logic [AW-1:0]   write_addr,
    input  logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            stall,
    output logic            pending_any
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  r_regs    [NREG];
    logic [CNT_W-1:0] r_cnt     [NREG];

    logic             w_wb_valid;
    logic             w_wb_hit  [NREG];
    logic [CNT_W-1:0] w_eff     [NREG];
    logic             w_inc     [NREG];
    logic [CNT_W-1:0] w_cnt_nxt [NREG];
    logic             w_issue_accept;

    // x0 is hardwired; writebacks to it are dropped everywhere.
    assign w_wb_valid = op_write && (write_addr != '0);

    // Effective count: a writeback landing this cycle already retires one
    // outstanding write, so readers of that register need not wait for it.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            w_wb_hit[i] = w_wb_valid && (write_addr == AW'(i));
            w_eff[i]    = (w_wb_hit[i] && (r_cnt[i] != '0)) ? (r_cnt[i] - CNT_W'(1))
                                                            : r_cnt[i];
        end
    end

    // Read ports: x0 -> 0, then same-cycle writeback bypass, then array.
    always_comb begin
        if (rs1_addr == '0)
            rs1_data = '0;
        else if (op_write && (write_addr == rs1_addr))
            rs1_data = write_data;
        else
            rs1_data = r_regs[rs1_addr];

        if (rs2_addr == '0)
            rs2_data = '0;
        else if (op_write && (write_addr == rs2_addr))
            rs2_data = write_data;
        else
            rs2_data = r_regs[rs2_addr];
    end

    // Stall on RAW hazard or when the destination counter would overflow.
    always_comb begin
        logic w_raw1;
        logic w_raw2;
        logic w_full;
        w_raw1 = rs1_used && (rs1_addr != '0) && (w_eff[rs1_addr] != '0);
        w_raw2 = rs2_used && (rs2_addr != '0) && (w_eff[rs2_addr] != '0);
        w_full = issue_valid && issue_we && (issue_rd != '0) && (w_eff[issue_rd] == CNT_MAX);
        stall  = !flush && (w_raw1 || w_raw2 || w_full);
    end

    assign w_issue_accept = issue_valid && !stall && !flush;

    // Next counter value: simultaneous inc and dec cancel; dec saturates at 0.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            w_inc[i]     = w_issue_accept && issue_we && (i != 0) && (issue_rd == AW'(i));
            w_cnt_nxt[i] = r_cnt[i];
            if (w_inc[i] && !w_wb_hit[i])
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            else if (!w_inc[i] && w_wb_hit[i] && (r_cnt[i] != '0))
                w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
        end
    end

    always_comb begin
        pending_any = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (r_cnt[i] != '0)
                pending_any = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++)
                r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    // Writeback is honoured during flush; only reset blocks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_wb_valid) begin
            r_regs[write_addr] <= write_data;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed bench for regfile_scoreboard. Inputs change right after a falling
// edge; combinational outputs are sampled 1 ns later, well away from the
// rising edge that commits state.
// ----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        op_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        stall;
    logic        pending_any;

    int n_checks;
    int n_errors;

    regfile_scoreboard #(
        .XLEN  (32),
        .NREG  (32),
        .CNT_W (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_write    (op_write),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .stall       (stall),
        .pending_any (pending_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; returns on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        rst         = 1'b0;
        op_write    = 1'b0;
        write_addr  = '0;
        write_data  = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic no_issue();
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        op_write   = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    task automatic no_wb();
        op_write   = 1'b0;
        write_addr = '0;
        write_data = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        settle();
        check("rst_rs1", rs1_data, 32'h0);
        check("rst_rs2", rs2_data, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_pend", {31'b0, pending_any}, 32'h0);

        // Write and same-cycle bypass
        wb(5'd7, 32'hDEADBEEF);
        rs1_addr = 5'd7;
        settle();
        check("bypass_rs1", rs1_data, 32'hDEADBEEF);
        tick();
        no_wb();
        settle();
        check("array_rs1", rs1_data, 32'hDEADBEEF);

        // Bypass on port 2 while port 1 reads the array
        wb(5'd12, 32'hA5A5_0F0F);
        rs2_addr = 5'd12;
        settle();
        check("bypass_rs2", rs2_data, 32'hA5A5_0F0F);
        check("rs1_unaffected", rs1_data, 32'hDEADBEEF);
        tick();

        // Write to x0 is dropped
        wb(5'd0, 32'h0000_1234);
        rs1_addr = 5'd0;
        settle();
        check("x0_bypass", rs1_data, 32'h0);
        tick();
        no_wb();
        rs2_addr = 5'd0;
        settle();
        check("x0_read", rs2_data, 32'h0);

        // Issue to x0 does not create a pending write
        issue(5'd0);
        tick();
        no_issue();
        settle();
        check("x0_no_pend", {31'b0, pending_any}, 32'h0);

        // RAW hazard on x3
        issue(5'd3);
        settle();
        check("raw_issue_ok", {31'b0, stall}, 32'h0);
        tick();
        no_issue();
        rs1_used = 1'b1;
        rs1_addr = 5'd3;
        settle();
        check("raw_pend", {31'b0, pending_any}, 32'h1);
        check("raw_stall", {31'b0, stall}, 32'h1);
        tick();
        wb(5'd3, 32'h0000_0055);
        settle();
        check("raw_wb_stall", {31'b0, stall}, 32'h0);
        check("raw_wb_data", rs1_data, 32'h0000_0055);
        tick();
        no_wb();
        settle();
        check("raw_done_pend", {31'b0, pending_any}, 32'h0);
        check("raw_done_stall", {31'b0, stall}, 32'h0);
        rs1_used = 1'b0;

        // Saturation on x9
        for (int k = 0; k < 3; k++) begin
            issue(5'd9);
            settle();
            check($sformatf("sat_issue%0d", k), {31'b0, stall}, 32'h0);
            tick();
        end
        issue(5'd9);
        settle();
        check("sat_full_stall", {31'b0, stall}, 32'h1);
        tick();
        no_issue();
        rs2_used = 1'b1;
        rs2_addr = 5'd9;
        settle();
        check("sat_held", {31'b0, stall}, 32'h1);
        // cnt 3 -> 2 -> 1 -> 0; eff is one below cnt during each writeback
        for (int k = 0; k < 3; k++) begin
            wb(5'd9, 32'h900 + k);
            settle();
            check($sformatf("sat_wb%0d_stall", k), {31'b0, stall}, (k == 2) ? 32'h0 : 32'h1);
            tick();
        end
        no_wb();
        settle();
        check("sat_pend", {31'b0, pending_any}, 32'h0);
        check("sat_data", rs2_data, 32'h902);
        rs2_used = 1'b0;

        // Simultaneous issue and writeback on x4
        issue(5'd4);
        tick();
        issue(5'd4);
        wb(5'd4, 32'h0000_0044);
        rs1_used = 1'b1;
        rs1_addr = 5'd4;
        settle();
        check("simul_stall", {31'b0, stall}, 32'h0);
        tick();
        no_issue();
        no_wb();
        settle();
        check("simul_next_stall", {31'b0, stall}, 32'h1);
        wb(5'd4, 32'h0000_0045);
        tick();
        no_wb();
        settle();
        check("simul_clear", {31'b0, pending_any}, 32'h0);
        rs1_used = 1'b0;

        // Flush: cnt[2]=2, cnt[6]=1, then flush with issue to x8
        issue(5'd2);
        tick();
        tick();
        issue(5'd6);
        tick();
        no_issue();
        settle();
        check("fl_pre_pend", {31'b0, pending_any}, 32'h1);
        flush    = 1'b1;
        issue(5'd8);
        wb(5'd6, 32'h0000_0066);
        rs1_used = 1'b1;
        rs1_addr = 5'd2;
        settle();
        check("fl_stall_forced", {31'b0, stall}, 32'h0);
        tick();
        flush = 1'b0;
        no_issue();
        no_wb();
        settle();
        check("fl_pend", {31'b0, pending_any}, 32'h0);
        check("fl_x2_stall", {31'b0, stall}, 32'h0);
        rs1_addr = 5'd8;
        settle();
        check("fl_x8_stall", {31'b0, stall}, 32'h0);
        rs2_addr = 5'd6;
        settle();
        check("fl_wb_kept", rs2_data, 32'h0000_0066);
        rs1_used = 1'b0;
        wb(5'd2, 32'h0000_2222);
        tick();
        no_wb();
        rs1_addr = 5'd2;
        settle();
        check("fl_late_pend", {31'b0, pending_any}, 32'h0);
        check("fl_late_data", rs1_data, 32'h0000_2222);

        // Reset clears pending state and the array
        issue(5'd5);
        tick();
        no_issue();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs1_addr = 5'd7;
        settle();
        check("rst2_pend", {31'b0, pending_any}, 32'h0);
        check("rst2_data", rs1_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
